count_frame_tx: RTL

COUNT_FRAME_TX -- requirements
Module: count_frame_tx

---
 rtl/count_frame_pkg.sv | 31 +++
 rtl/count_frame_tx_if.sv | 10 +
 rtl/uart_byte_tx.sv | 110 +++++++++++
 rtl/count_frame_tx.sv | 127 ++++++++++++
 4 files changed

// File: rtl/count_frame_pkg.sv
// Shared state encodings, parity-mode constants and frame defaults for the
// count_frame_tx UART framer.
package count_frame_pkg;

  typedef enum logic [1:0] {
    FRM_IDLE,
    FRM_SYNC,
    FRM_DATA,
    FRM_CHK
  } frame_state_e;

  typedef enum logic [2:0] {
    BYTE_IDLE,
    BYTE_START,
    BYTE_DATA,
    BYTE_PARITY,
    BYTE_STOP
  } byte_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Even mode makes the total count of ones even; odd mode makes it odd.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/count_frame_tx_if.sv
// Byte-level valid/ready handshake between the frame sequencer and the
// UART byte serialiser.
interface count_frame_tx_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input byte_ready);
  modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/uart_byte_tx.sv
// UART byte serialiser: start, 8 data bits LSB first, optional parity, stop bits.
// Ready rises in the final stop-bit cycle so the next byte follows with no gap.
module uart_byte_tx
  import count_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_MODE  = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  count_frame_tx_if.slave  byte_if,
  output logic             o_Tx_Serial
);

  localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
  localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

  byte_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        stop_idx_q, stop_idx_d;
  logic [7:0]  data_q, data_d;
  logic        tx_q, tx_d;
  logic        bit_end;
  logic        ready;

  assign bit_end = (cnt_q == LAST_CNT);
  assign ready   = (state_q == BYTE_IDLE) ||
                   ((state_q == BYTE_STOP) && bit_end && (stop_idx_q == LAST_STOP));
  assign byte_if.byte_ready = ready;
  assign o_Tx_Serial        = tx_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = (state_q == BYTE_IDLE || bit_end) ? 16'd0 : cnt_q + 16'd1;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    data_d     = data_q;
    tx_d       = tx_q;
    unique case (state_q)
      BYTE_IDLE: ;
      BYTE_START: begin
        if (bit_end) begin
          state_d   = BYTE_DATA;
          bit_idx_d = 3'd0;
          tx_d      = data_q[0];
        end
      end
      BYTE_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            if (PARITY_MODE != PARITY_NONE) begin
              state_d = BYTE_PARITY;
              tx_d    = parity_bit(data_q, PARITY_MODE);
            end else begin
              state_d    = BYTE_STOP;
              stop_idx_d = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = data_q[bit_idx_q + 3'd1];
          end
        end
      end
      BYTE_PARITY: begin
        if (bit_end) begin
          state_d    = BYTE_STOP;
          stop_idx_d = 1'b0;
          tx_d       = 1'b1;
        end
      end
      BYTE_STOP: begin
        if (bit_end && (stop_idx_q != LAST_STOP)) stop_idx_d = stop_idx_q + 1'b1;
      end
      default: state_d = BYTE_IDLE;
    endcase
    // Handshake overrides: a waiting byte starts immediately, else go idle high.
    if (ready) begin
      if (byte_if.byte_valid) begin
        state_d = BYTE_START;
        data_d  = byte_if.byte_data;
        tx_d    = 1'b0;
      end else begin
        state_d = BYTE_IDLE;
        tx_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= BYTE_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      data_q     <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      data_q     <= data_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: rtl/count_frame_tx.sv
// Frame sequencer: sends SYNC_BYTE, a counter snapshot MSB first and an XOR
// checksum over UART, then bumps the counter at frame end unless held.
module count_frame_tx
  import count_frame_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         COUNT_BYTES  = 2,
  parameter int         PARITY_MODE  = PARITY_NONE,
  parameter int         STOP_BITS    = 1,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst_n,
  input  logic                       i_Enable,
  input  logic                       i_Hold,
  output logic                       o_Tx_Serial,
  output logic                       o_Tx_Active,
  output logic                       o_Frame_Done,
  output logic [8*COUNT_BYTES-1:0]   o_Count
);

  localparam int         CW       = 8 * COUNT_BYTES;
  localparam logic [1:0] LAST_IDX = 2'(COUNT_BYTES - 1);

  count_frame_tx_if byte_if ();

  frame_state_e  state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] snap_q, snap_d;
  logic [1:0]    idx_q, idx_d;
  logic          done_q, done_d;
  logic          frame_end;

  // Byte k of the snapshot, k = 0 being the most significant.
  function automatic logic [7:0] snap_byte(input logic [CW-1:0] v, input logic [1:0] k);
    logic [CW-1:0] s;
    s = v >> (8 * (COUNT_BYTES - 1 - int'(k)));
    return s[7:0];
  endfunction

  function automatic logic [7:0] checksum(input logic [CW-1:0] v);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < COUNT_BYTES; i++) x ^= v[8*i +: 8];
    return x;
  endfunction

  assign frame_end    = (state_q == FRM_CHK) && byte_if.byte_ready;
  assign o_Tx_Active  = (state_q != FRM_IDLE);
  assign o_Frame_Done = done_q;
  assign o_Count      = count_q;

  // The handshake fires in the last stop-bit cycle of the current byte, so
  // the data offered in each state is the byte that follows it.
  always_comb begin
    state_d            = state_q;
    count_d            = count_q;
    snap_d             = snap_q;
    idx_d              = idx_q;
    done_d             = 1'b0;
    byte_if.byte_valid = 1'b0;
    byte_if.byte_data  = SYNC_BYTE;
    unique case (state_q)
      FRM_IDLE: byte_if.byte_valid = i_Enable;
      FRM_SYNC: begin
        byte_if.byte_valid = 1'b1;
        byte_if.byte_data  = snap_byte(snap_q, 2'd0);
        if (byte_if.byte_ready) begin
          state_d = FRM_DATA;
          idx_d   = 2'd0;
        end
      end
      FRM_DATA: begin
        byte_if.byte_valid = 1'b1;
        if (idx_q == LAST_IDX) begin
          byte_if.byte_data = checksum(snap_q);
          if (byte_if.byte_ready) state_d = FRM_CHK;
        end else begin
          byte_if.byte_data = snap_byte(snap_q, idx_q + 2'd1);
          if (byte_if.byte_ready) idx_d = idx_q + 2'd1;
        end
      end
      FRM_CHK: begin
        byte_if.byte_valid = i_Enable;
        if (frame_end) begin
          done_d  = 1'b1;
          state_d = FRM_IDLE;
          if (!i_Hold) count_d = count_q + CW'(1);
        end
      end
      default: state_d = FRM_IDLE;
    endcase
    // A back-to-back restart snapshots the freshly incremented count.
    if ((state_q == FRM_IDLE || frame_end) && i_Enable && byte_if.byte_ready) begin
      state_d = FRM_SYNC;
      snap_d  = count_d;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= FRM_IDLE;
      count_q <= '0;
      snap_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .PARITY_MODE  (PARITY_MODE),
    .STOP_BITS    (STOP_BITS)
  ) u_byte_tx (
    .i_Clk       (i_Clk),
    .i_Rst_n     (i_Rst_n),
    .byte_if     (byte_if.slave),
    .o_Tx_Serial (o_Tx_Serial)
  );

endmodule
